// File: rtl/spram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NUM_REQ requesters.
// Grants are combinational; read responses are tagged through a latency-matched pipeline.
module spram_rr_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          ram_en,
    output logic                          ram_we,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_din,
    input  logic [DATA_WIDTH-1:0]         ram_dout
);

    localparam int ID_W = (NUM_REQ > 2) ? 2 : 1;

    logic [ID_W-1:0]       r_prio;
    logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_REQ];
    logic                  w_found;
    logic [ID_W-1:0]       w_win;
    logic                  w_accept;
    int                    w_idx;

    logic                  r_pipe_vld [READ_LATENCY];
    logic [ID_W-1:0]       r_pipe_id  [READ_LATENCY];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Scan from the priority pointer upward with wrap; first valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(r_prio) + k) % NUM_REQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = ID_W'(w_idx);
            end
        end
    end

    assign w_accept = w_found && !rst;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_win] = 1'b1;
        end
    end

    assign ram_en   = w_accept;
    assign ram_we   = w_accept && req_we[w_win];
    assign ram_addr = w_addr_arr[w_win];
    assign ram_din  = w_wdata_arr[w_win];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= '0;
        end else if (w_accept) begin
            r_prio <= (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
        end
    end

    // Stage 0 captures each accepted read; later stages just delay it to match RAM latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld[0] <= 1'b0;
        end else begin
            r_pipe_vld[0] <= w_accept && !req_we[w_win];
        end
        r_pipe_id[0] <= w_win;
    end

    generate
        for (gi = 1; gi < READ_LATENCY; gi++) begin : g_pipe
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pipe_vld[gi] <= 1'b0;
                end else begin
                    r_pipe_vld[gi] <= r_pipe_vld[gi-1];
                end
                r_pipe_id[gi] <= r_pipe_id[gi-1];
            end
        end
    endgenerate

    always_comb begin
        rsp_valid = '0;
        if (!rst && r_pipe_vld[READ_LATENCY-1]) begin
            rsp_valid[r_pipe_id[READ_LATENCY-1]] = 1'b1;
        end
    end

    assign rsp_rdata = ram_dout;

endmodule

// File: tb/tb_spram_rr_arbiter.sv
// Two arbiters (read latency 1 and 2) share one stimulus stream; each drives its own RAM model
// and is compared every cycle against a behavioural round-robin / response-schedule model.
module tb_spram_rr_arbiter;

    localparam int NR = 2;
    localparam int DW = 32;
    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_we;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;

    logic [NR-1:0] ready_a, rspv_a, ready_b, rspv_b;
    logic [DW-1:0] rdata_a, rdata_b, din_a, din_b, dout_a, dout_b;
    logic [AW-1:0] addr_a, addr_b;
    logic          en_a, we_a, en_b, we_b;

    spram_rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(ready_a), .rsp_valid(rspv_a), .rsp_rdata(rdata_a),
        .ram_en(en_a), .ram_we(we_a), .ram_addr(addr_a), .ram_din(din_a), .ram_dout(dout_a)
    );

    spram_rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(ready_b), .rsp_valid(rspv_b), .rsp_rdata(rdata_b),
        .ram_en(en_b), .ram_we(we_b), .ram_addr(addr_b), .ram_din(din_b), .ram_dout(dout_b)
    );

    // RAM models: sync write, registered read of 1 and 2 cycles.
    bit   [DW-1:0] mem_a [1024];
    bit   [DW-1:0] mem_b [1024];
    logic [DW-1:0] rd_a, rd_b1, rd_b2;

    always @(posedge clk) begin
        if (en_a) begin
            if (we_a) mem_a[addr_a] <= din_a;
            else      rd_a <= mem_a[addr_a];
        end
        if (en_b) begin
            if (we_b) mem_b[addr_b] <= din_b;
            else      rd_b1 <= mem_b[addr_b];
        end
        rd_b2 <= rd_b1;
    end
    assign dout_a = rd_a;
    assign dout_b = rd_b2;

    // Reference model state.
    int          m_prio;
    bit [DW-1:0] m_mem [1024];
    bit          e_vld [2][4];
    int          e_id  [2][4];
    bit [DW-1:0] e_dat [2][4];
    int          cyc;
    int          n_checks;
    int          n_fail;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input bit v, input bit w, input int a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_we[i]             = w;
        req_addr[i*AW +: AW]  = AW'(a);
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, 0, '0);
    endtask

    // One clock cycle: check combinational outputs at negedge, then advance the model at posedge.
    task automatic step();
        int            w;
        int            idx;
        int            slot;
        logic [NR-1:0] exp_rv;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            is_wr;
        @(negedge clk);
        w = -1;
        if (!rst) begin
            for (int k = 0; k < NR; k++) begin
                idx = (m_prio + k) % NR;
                if (w < 0 && req_valid[idx]) w = idx;
            end
        end
        a     = (w >= 0) ? req_addr[w*AW +: AW] : '0;
        d     = (w >= 0) ? req_wdata[w*DW +: DW] : '0;
        is_wr = (w >= 0) ? req_we[w] : 1'b0;

        check_val("ready_l1", 64'(ready_a), (w >= 0) ? 64'(1 << w) : 64'd0);
        check_val("ready_l2", 64'(ready_b), (w >= 0) ? 64'(1 << w) : 64'd0);
        check_val("ram_en_l1", 64'(en_a), 64'(w >= 0));
        check_val("ram_en_l2", 64'(en_b), 64'(w >= 0));
        check_val("ram_we_l1", 64'(we_a), 64'(is_wr));
        check_val("ram_we_l2", 64'(we_b), 64'(is_wr));
        if (w >= 0) begin
            check_val("ram_addr_l1", 64'(addr_a), 64'(a));
            check_val("ram_addr_l2", 64'(addr_b), 64'(a));
            if (is_wr) begin
                check_val("ram_din_l1", 64'(din_a), 64'(d));
                check_val("ram_din_l2", 64'(din_b), 64'(d));
            end
            $display("cyc=%0d grant=%0d %s addr=%h data=%h", cyc, w, is_wr ? "WR" : "RD", a,
                     is_wr ? d : m_mem[a]);
        end

        slot = cyc % 4;
        for (int n = 0; n < 2; n++) begin
            exp_rv = (!rst && e_vld[n][slot]) ? NR'(1 << e_id[n][slot]) : '0;
            if (n == 0) check_val("rsp_valid_l1", 64'(rspv_a), 64'(exp_rv));
            else        check_val("rsp_valid_l2", 64'(rspv_b), 64'(exp_rv));
            if (exp_rv != '0) begin
                if (n == 0) check_val("rsp_rdata_l1", 64'(rdata_a), 64'(e_dat[n][slot]));
                else        check_val("rsp_rdata_l2", 64'(rdata_b), 64'(e_dat[n][slot]));
            end
            e_vld[n][slot] = 1'b0;
        end

        @(posedge clk);
        if (rst) begin
            m_prio = 0;
            for (int n = 0; n < 2; n++)
                for (int s = 0; s < 4; s++) e_vld[n][s] = 1'b0;
        end else if (w >= 0) begin
            m_prio = (w + 1) % NR;
            if (is_wr) begin
                m_mem[a] = d;
            end else begin
                for (int n = 0; n < 2; n++) begin
                    slot           = (cyc + n + 1) % 4;
                    e_vld[n][slot] = 1'b1;
                    e_id[n][slot]  = w;
                    e_dat[n][slot] = m_mem[a];
                end
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        m_prio   = 0;
        for (int n = 0; n < 2; n++)
            for (int s = 0; s < 4; s++) e_vld[n][s] = 1'b0;
        rst = 1'b1;
        clear_reqs();
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();

        // Both write together: grants must alternate starting with requester 0.
        set_req(0, 1'b1, 1'b1, 'h010, 32'hAAAA0000);
        set_req(1, 1'b1, 1'b1, 'h020, 32'hBBBB1111);
        for (int i = 0; i < 4; i++) step();
        clear_reqs();

        set_req(0, 1'b1, 1'b0, 'h020, '0);
        step();
        clear_reqs();
        for (int i = 0; i < 3; i++) step();

        set_req(1, 1'b1, 1'b0, 'h010, '0); step();
        set_req(1, 1'b1, 1'b0, 'h020, '0); step();
        set_req(1, 1'b1, 1'b0, 'h010, '0); step();
        clear_reqs();
        for (int i = 0; i < 3; i++) step();

        set_req(0, 1'b1, 1'b0, 'h010, '0); step();
        clear_reqs();
        set_req(1, 1'b1, 1'b0, 'h020, '0); step();
        clear_reqs();
        for (int i = 0; i < 3; i++) step();

        // Read in flight when reset hits: its response must be dropped.
        set_req(0, 1'b1, 1'b0, 'h020, '0); step();
        clear_reqs();
        rst = 1'b1; step(); step();
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 'h010, '0);
        set_req(1, 1'b1, 1'b0, 'h020, '0);
        step(); step();
        clear_reqs();
        for (int i = 0; i < 3; i++) step();

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int r = 0; r < NR; r++)
                set_req(r, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        $urandom_range(0, 15), $urandom);
            step();
        end
        rst = 1'b0;
        clear_reqs();
        for (int i = 0; i < 4; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
